// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 PHY arbiter: FSM state encoding,
// mux source select, counter widths and the PHY idle (blanked) values.
package hub75_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2,
    ST_GUARD = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_A    = 2'd1,
    SRC_B    = 2'd2
  } phy_src_t;

  localparam int unsigned GUARD_CNT_W = 8;
  localparam int unsigned WD_CNT_W    = 16;

  // Values driven onto the PHY while nobody owns it
  localparam logic IDLE_ADDR_INC = 1'b0;
  localparam logic IDLE_ADDR_RST = 1'b0;
  localparam logic IDLE_CLK      = 1'b0;
  localparam logic IDLE_LE       = 1'b0;
  localparam logic IDLE_BLANK    = 1'b1;

endpackage

// File: rtl/hub75_phy_arb_mux.sv
// Output register and source mux for the arbitrated HUB75 PHY.
// sel names the source for the next cycle; anything other than A/B
// drives idle values while the row address holds its last value.
module hub75_phy_arb_mux
  import hub75_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  phy_src_t          sel,
  input  logic              a_addr_inc,
  input  logic              a_addr_rst,
  input  logic              a_clk,
  input  logic              a_le,
  input  logic              a_blank,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_addr_inc,
  input  logic              b_addr_rst,
  input  logic              b_clk,
  input  logic              b_le,
  input  logic              b_blank,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              phy_out_addr_inc,
  output logic              phy_out_addr_rst,
  output logic              phy_out_clk,
  output logic              phy_out_le,
  output logic              phy_out_blank,
  output logic [ADDR_W-1:0] phy_out_addr,
  output logic [DATA_W-1:0] phy_out_data
);

  // Register the selected requester, or blank the PHY when unowned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phy_out_addr_inc <= IDLE_ADDR_INC;
      phy_out_addr_rst <= IDLE_ADDR_RST;
      phy_out_clk      <= IDLE_CLK;
      phy_out_le       <= IDLE_LE;
      phy_out_blank    <= IDLE_BLANK;
      phy_out_addr     <= '0;
      phy_out_data     <= '0;
    end else begin
      case (sel)
        SRC_A: begin
          phy_out_addr_inc <= a_addr_inc;
          phy_out_addr_rst <= a_addr_rst;
          phy_out_clk      <= a_clk;
          phy_out_le       <= a_le;
          phy_out_blank    <= a_blank;
          phy_out_addr     <= a_addr;
          phy_out_data     <= a_data;
        end
        SRC_B: begin
          phy_out_addr_inc <= b_addr_inc;
          phy_out_addr_rst <= b_addr_rst;
          phy_out_clk      <= b_clk;
          phy_out_le       <= b_le;
          phy_out_blank    <= b_blank;
          phy_out_addr     <= b_addr;
          phy_out_data     <= b_data;
        end
        default: begin
          phy_out_addr_inc <= IDLE_ADDR_INC;
          phy_out_addr_rst <= IDLE_ADDR_RST;
          phy_out_clk      <= IDLE_CLK;
          phy_out_le       <= IDLE_LE;
          phy_out_blank    <= IDLE_BLANK;
          phy_out_data     <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hub75_phy_arb.sv
// HUB75 PHY ownership arbiter between the scan engine (A) and the init
// injector (B). Non-preemptive ownership, alternating tie-break, and a
// blanked guard interval after every release.
// Optional watchdog: define HUB75_ARB_TIMEOUT_EN to revoke an ownership
// that is held for TIMEOUT cycles while the other side is waiting.
module hub75_phy_arb
  import hub75_pkg::*;
#(
  parameter int unsigned LOG_N_ROWS   = 5,
  parameter int unsigned N_CHANS      = 2,
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_req,
  input  logic                    b_req,
  output logic                    a_gnt,
  output logic                    b_gnt,
  input  logic                    a_phy_addr_inc,
  input  logic                    a_phy_addr_rst,
  input  logic                    a_phy_clk,
  input  logic                    a_phy_le,
  input  logic                    a_phy_blank,
  input  logic [LOG_N_ROWS-1:0]   a_phy_addr,
  input  logic [N_CHANS*3-1:0]    a_phy_data,
  input  logic                    b_phy_addr_inc,
  input  logic                    b_phy_addr_rst,
  input  logic                    b_phy_clk,
  input  logic                    b_phy_le,
  input  logic                    b_phy_blank,
  input  logic [LOG_N_ROWS-1:0]   b_phy_addr,
  input  logic [N_CHANS*3-1:0]    b_phy_data,
  output logic                    phy_out_addr_inc,
  output logic                    phy_out_addr_rst,
  output logic                    phy_out_clk,
  output logic                    phy_out_le,
  output logic                    phy_out_blank,
  output logic [LOG_N_ROWS-1:0]   phy_out_addr,
  output logic [N_CHANS*3-1:0]    phy_out_data,
  output logic                    arb_timeout
);

  localparam int unsigned DATA_W = N_CHANS * 3;

  // Elaboration-time parameter range checks
  if (GUARD_CYCLES < 1 || GUARD_CYCLES > 255) begin : g_bad_guard
    $error("hub75_phy_arb: GUARD_CYCLES must be 1..255");
  end
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("hub75_phy_arb: TIMEOUT must be 2..65535");
  end

  arb_state_t             state;
  arb_state_t             state_nxt;
  logic                   last_b;      // B was the most recent owner
  logic [GUARD_CNT_W-1:0] guard_cnt;
  logic                   wd_hit_c;
  logic                   a_gnt_nxt;
  logic                   b_gnt_nxt;
  logic                   guard_load_c;
  phy_src_t               sel_c;

`ifdef HUB75_ARB_TIMEOUT_EN
  logic [WD_CNT_W-1:0] wd_cnt;
  logic                contested_c;

  assign contested_c = ((state == ST_OWN_A) && b_req) || ((state == ST_OWN_B) && a_req);
  assign wd_hit_c    = contested_c && (wd_cnt == WD_CNT_W'(TIMEOUT - 1));

  // Watchdog: count contested ownership cycles; flag is sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt      <= '0;
      arb_timeout <= 1'b0;
    end else begin
      if ((state_nxt != ST_OWN_A) && (state_nxt != ST_OWN_B)) begin
        wd_cnt <= '0;
      end else if (contested_c) begin
        wd_cnt <= wd_cnt + WD_CNT_W'(1);
      end
      if (wd_hit_c) begin
        arb_timeout <= 1'b1;
      end
    end
  end
`else
  assign wd_hit_c    = 1'b0;
  assign arb_timeout = 1'b0;
`endif

  // State, grant, last-owner and guard-counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_gnt     <= 1'b0;
      b_gnt     <= 1'b0;
      last_b    <= 1'b0;
      guard_cnt <= '0;
    end else begin
      state <= state_nxt;
      a_gnt <= a_gnt_nxt;
      b_gnt <= b_gnt_nxt;
      if ((state == ST_IDLE) && (state_nxt == ST_OWN_A)) begin
        last_b <= 1'b0;
      end else if ((state == ST_IDLE) && (state_nxt == ST_OWN_B)) begin
        last_b <= 1'b1;
      end
      if (guard_load_c) begin
        guard_cnt <= GUARD_CNT_W'(GUARD_CYCLES);
      end else if ((state == ST_GUARD) && (guard_cnt != '0)) begin
        guard_cnt <= guard_cnt - GUARD_CNT_W'(1);
      end
    end
  end

  // Next-state: tie goes to whoever did not own most recently
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (a_req && b_req) begin
          state_nxt = last_b ? ST_OWN_A : ST_OWN_B;
        end else if (b_req) begin
          state_nxt = ST_OWN_B;
        end else if (a_req) begin
          state_nxt = ST_OWN_A;
        end
      end
      ST_OWN_A: begin
        if (!a_req || wd_hit_c) begin
          state_nxt = ST_GUARD;
        end
      end
      ST_OWN_B: begin
        if (!b_req || wd_hit_c) begin
          state_nxt = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (guard_cnt <= GUARD_CNT_W'(1)) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: grants and mux source follow the upcoming state so they
  // register in step with the state itself
  always_comb begin
    a_gnt_nxt    = 1'b0;
    b_gnt_nxt    = 1'b0;
    sel_c        = SRC_NONE;
    guard_load_c = (state_nxt == ST_GUARD) && (state != ST_GUARD);
    case (state_nxt)
      ST_OWN_A: begin
        a_gnt_nxt = 1'b1;
        sel_c     = SRC_A;
      end
      ST_OWN_B: begin
        b_gnt_nxt = 1'b1;
        sel_c     = SRC_B;
      end
      default: ;
    endcase
  end

  hub75_phy_arb_mux #(
    .ADDR_W (LOG_N_ROWS),
    .DATA_W (DATA_W)
  ) u_mux (
    .clk              (clk),
    .rst              (rst),
    .sel              (sel_c),
    .a_addr_inc       (a_phy_addr_inc),
    .a_addr_rst       (a_phy_addr_rst),
    .a_clk            (a_phy_clk),
    .a_le             (a_phy_le),
    .a_blank          (a_phy_blank),
    .a_addr           (a_phy_addr),
    .a_data           (a_phy_data),
    .b_addr_inc       (b_phy_addr_inc),
    .b_addr_rst       (b_phy_addr_rst),
    .b_clk            (b_phy_clk),
    .b_le             (b_phy_le),
    .b_blank          (b_phy_blank),
    .b_addr           (b_phy_addr),
    .b_data           (b_phy_data),
    .phy_out_addr_inc (phy_out_addr_inc),
    .phy_out_addr_rst (phy_out_addr_rst),
    .phy_out_clk      (phy_out_clk),
    .phy_out_le       (phy_out_le),
    .phy_out_blank    (phy_out_blank),
    .phy_out_addr     (phy_out_addr),
    .phy_out_data     (phy_out_data)
  );

endmodule

// File: tb/tb_hub75_phy_arb.sv
// Self-checking bench for hub75_phy_arb (GUARD_CYCLES=4, TIMEOUT=16).
module tb_hub75_phy_arb;

  localparam int unsigned TB_GUARD   = 4;
  localparam int unsigned TB_TIMEOUT = 16;
  // control bit order: {addr_inc, addr_rst, clk, le, blank}
  localparam logic [4:0] CTL_IDLE = 5'b00001;
  localparam logic [4:0] A_CTL_K  = 5'b10100;
  localparam logic [4:0] B_CTL_K  = 5'b01010;
  localparam logic [4:0] A_ADDR_K = 5'h07;
  localparam logic [4:0] B_ADDR_K = 5'h03;
  localparam logic [5:0] A_DATA_K = 6'h2A;
  localparam logic [5:0] B_DATA_K = 6'h15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req = 1'b0, b_req = 1'b0;
  logic [4:0] a_ctl, b_ctl, a_addr, b_addr;
  logic [5:0] a_data, b_data;
  logic       a_gnt, b_gnt, arb_timeout;
  logic       o_inc, o_rst, o_clk, o_le, o_blank;
  logic [4:0] o_addr;
  logic [5:0] o_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hub75_phy_arb #(
    .LOG_N_ROWS(5), .N_CHANS(2), .GUARD_CYCLES(TB_GUARD), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .b_req(b_req), .a_gnt(a_gnt), .b_gnt(b_gnt),
    .a_phy_addr_inc(a_ctl[4]), .a_phy_addr_rst(a_ctl[3]), .a_phy_clk(a_ctl[2]),
    .a_phy_le(a_ctl[1]), .a_phy_blank(a_ctl[0]), .a_phy_addr(a_addr), .a_phy_data(a_data),
    .b_phy_addr_inc(b_ctl[4]), .b_phy_addr_rst(b_ctl[3]), .b_phy_clk(b_ctl[2]),
    .b_phy_le(b_ctl[1]), .b_phy_blank(b_ctl[0]), .b_phy_addr(b_addr), .b_phy_data(b_data),
    .phy_out_addr_inc(o_inc), .phy_out_addr_rst(o_rst), .phy_out_clk(o_clk),
    .phy_out_le(o_le), .phy_out_blank(o_blank), .phy_out_addr(o_addr), .phy_out_data(o_data),
    .arb_timeout(arb_timeout)
  );

  // ---------------- reference model (ownership as plain integers) -------------
  int         m_owner;   // 0 none, 1 A, 2 B
  int         m_guard;   // blanked cycles still to run
  int         m_last;    // most recent owner
  int         m_wd;      // contested cycles in current ownership
  logic       m_to;
  logic [4:0] m_ctl, m_addr;
  logic [5:0] m_data;

  task automatic model_reset();
    m_owner = 0; m_guard = 0; m_last = 1; m_wd = 0; m_to = 1'b0;
    m_ctl = CTL_IDLE; m_addr = 5'd0; m_data = 6'd0;
  endtask

  task automatic model_step();
    int   nxt;
    logic mine, other, hit;
    nxt = m_owner;
    hit = 1'b0;
    if (m_owner == 0 && m_guard == 0) begin
      if (a_req && b_req) nxt = (m_last == 1) ? 2 : 1;
      else if (b_req)     nxt = 2;
      else if (a_req)     nxt = 1;
      else                nxt = 0;
      if (nxt != 0) m_last = nxt;
    end else if (m_owner != 0) begin
      mine  = (m_owner == 1) ? a_req : b_req;
      other = (m_owner == 1) ? b_req : a_req;
`ifdef HUB75_ARB_TIMEOUT_EN
      if (other) m_wd++;
      hit = other && (m_wd >= int'(TB_TIMEOUT));
`endif
      if (!mine || hit) begin
        nxt = 0;
        m_guard = TB_GUARD;
        m_wd = 0;
        if (hit) m_to = 1'b1;
      end
    end else begin
      m_guard--;
    end
    m_owner = nxt;
    case (m_owner)
      1: begin m_ctl = a_ctl; m_addr = a_addr; m_data = a_data; end
      2: begin m_ctl = b_ctl; m_addr = b_addr; m_data = b_data; end
      default: begin m_ctl = CTL_IDLE; m_data = 6'd0; end
    endcase
  endtask

  // ---------------- helpers ---------------------------------------------------
  function automatic logic [18:0] dut_vec();
    return {a_gnt, b_gnt, arb_timeout, o_inc, o_rst, o_clk, o_le, o_blank, o_addr, o_data};
  endfunction

  function automatic logic [18:0] exp_vec(logic ag, logic bg, logic to, int src, logic [4:0] addr);
    logic [4:0] c;
    logic [5:0] d;
    c = (src == 1) ? A_CTL_K : (src == 2) ? B_CTL_K : CTL_IDLE;
    d = (src == 1) ? A_DATA_K : (src == 2) ? B_DATA_K : 6'd0;
    return {ag, bg, to, c, addr, d};
  endfunction

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Asynchronous reset: outputs must go idle before any clock edge
  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
    a_ctl = A_CTL_K; a_addr = A_ADDR_K; a_data = A_DATA_K;
    b_ctl = B_CTL_K; b_addr = B_ADDR_K; b_data = B_DATA_K;
    #1;
    check(name, dut_vec(), {3'b000, CTL_IDLE, 5'd0, 6'd0});
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cycle(input logic a, input logic b);
    @(negedge clk);
    a_req = a; b_req = b;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table --------------------------------------------
  typedef struct {
    logic       a_req;
    logic       b_req;
    logic       ea;
    logic       eb;
    int         src;
    logic [4:0] eaddr;
  } vec_t;

  vec_t vecs[22];

  initial begin
    logic [1:0] pe;
    logic [2:0] we;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 5'h00};  // idle after reset
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2, B_ADDR_K}; // tie after reset: B
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2, B_ADDR_K};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, B_ADDR_K}; // B releases -> guard
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, B_ADDR_K};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, B_ADDR_K};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, B_ADDR_K};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, B_ADDR_K}; // idle decision
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1, A_ADDR_K}; // A granted
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1, A_ADDR_K}; // no preemption
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, A_ADDR_K};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, A_ADDR_K};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, A_ADDR_K};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, A_ADDR_K};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, A_ADDR_K};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 2, B_ADDR_K};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, B_ADDR_K};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, B_ADDR_K}; // both wait in guard
    vecs[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, B_ADDR_K};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, B_ADDR_K};
    vecs[20] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, B_ADDR_K};
    vecs[21] = '{1'b1, 1'b1, 1'b1, 1'b0, 1, A_ADDR_K}; // tie after B: A

    model_reset();
    do_reset("reset_initial");
    for (int i = 0; i < 22; i++) begin
      cycle(vecs[i].a_req, vecs[i].b_req);
      check($sformatf("vec%0d", i), dut_vec(),
            exp_vec(vecs[i].ea, vecs[i].eb, 1'b0, vecs[i].src, vecs[i].eaddr));
    end

    // Reset while A owns the PHY
    do_reset("reset_during_own_a");

    // One-cycle A pulse: one owned cycle, full guard, then B
    for (int i = 0; i < 7; i++) begin
      cycle(i == 0, i != 0);
      pe = (i == 0) ? 2'b10 : (i == 6) ? 2'b01 : 2'b00;
      check($sformatf("pulse%0d", i), 19'({a_gnt, b_gnt}), 19'(pe));
    end

    // Watchdog: A holds while B waits
    do_reset("reset_before_wd");
    for (int i = 1; i <= 30; i++) begin
      cycle(1'b1, i >= 2);
`ifdef HUB75_ARB_TIMEOUT_EN
      we = {i <= 16, i >= 22, i >= 17};
`else
      we = 3'b100;
`endif
      check($sformatf("wd%0d", i), 19'({a_gnt, b_gnt, arb_timeout}), 19'(we));
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0);
`ifdef HUB75_ARB_TIMEOUT_EN
    check("wd_sticky", 19'(arb_timeout), 19'(1'b1));
`else
    check("wd_sticky", 19'(arb_timeout), 19'(1'b0));
`endif

    // Randomised traffic against the model
    do_reset("reset_before_rand");
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) a_req = ~a_req;
      if ($urandom_range(7) == 0) b_req = ~b_req;
      a_ctl = 5'($urandom); a_addr = 5'($urandom); a_data = 6'($urandom);
      b_ctl = 5'($urandom); b_addr = 5'($urandom); b_data = 6'($urandom);
      model_step();
      @(posedge clk);
      #1;
      check($sformatf("rand%0d", i), dut_vec(),
            {m_owner == 1, m_owner == 2, m_to, m_ctl, m_addr, m_data});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hub75_phy_arb.md
HUB75_PHY_ARB -- requirements
Module: hub75_phy_arb

Interface
REQ-001 Parameter LOG_N_ROWS, default 5: PHY row address width.
REQ-002 Parameter N_CHANS, default 2: PHY data width is N_CHANS*3 bits.
REQ-003 Parameter GUARD_CYCLES, default 4, range 1..255: blanked cycles inserted after each ownership release.
REQ-004 Parameter TIMEOUT, default 1024, range 2..65535: ownership watchdog limit in cycles; used only when HUB75_ARB_TIMEOUT_EN is defined.
REQ-005 Port clk, input, 1 bit: single clock; all state is on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Ports a_req / b_req, input, 1 bit each: ownership request from requester A (scan engine) and requester B (init injector).
REQ-008 Ports a_gnt / b_gnt, output, 1 bit each: ownership grant; at most one SHALL be high in any cycle.
REQ-009 Ports a_phy_addr_inc, a_phy_addr_rst, a_phy_clk, a_phy_le, a_phy_blank, input, 1 bit each: requester A PHY controls; b_phy_* SHALL be the identical set for requester B.
REQ-010 Ports a_phy_addr / b_phy_addr, input, LOG_N_ROWS bits: requester row address.
REQ-011 Ports a_phy_data / b_phy_data, input, N_CHANS*3 bits: requester pixel data.
REQ-012 Ports phy_out_addr_inc, phy_out_addr_rst, phy_out_clk, phy_out_le, phy_out_blank, output, 1 bit each: arbitrated PHY controls.
REQ-013 Ports phy_out_addr (LOG_N_ROWS bits) and phy_out_data (N_CHANS*3 bits), output: arbitrated PHY address and data.
REQ-014 Port arb_timeout, output, 1 bit: sticky watchdog flag.

Function
REQ-015 The FSM SHALL have states IDLE, OWN_A, OWN_B, GUARD.
REQ-016 In IDLE with only b_req high, the FSM SHALL enter OWN_B; with only a_req high it SHALL enter OWN_A; with neither high it SHALL stay in IDLE.
REQ-017 In IDLE with both requests high, the FSM SHALL grant the requester that did not own the PHY most recently; after reset, B SHALL win the tie.
REQ-018 The x_gnt output SHALL be registered and high exactly while the FSM is in OWN_x, so it rises one cycle after the IDLE->OWN_x decision.
REQ-019 Ownership SHALL be non-preemptive: OWN_x SHALL persist while x_req is high.
REQ-020 When x_req drops in OWN_x, x_gnt SHALL fall on the next edge and the FSM SHALL enter GUARD.
REQ-021 GUARD SHALL last exactly GUARD_CYCLES cycles, counted by an 8-bit down-counter, and SHALL then return to IDLE.
REQ-022 In OWN_x, all phy_out_* SHALL be registered copies of the x_phy_* inputs, giving one cycle of latency.
REQ-023 In IDLE and GUARD the outputs SHALL take idle values: phy_out_blank=1; phy_out_clk, phy_out_le, phy_out_addr_inc and phy_out_addr_rst = 0; phy_out_data=0; phy_out_addr holding its last value.
REQ-024 Inputs from a non-owning requester SHALL never reach phy_out_*.
REQ-025 A request asserted during GUARD SHALL be served only after GUARD ends; GUARD SHALL NOT be shortened.
REQ-026 A one-cycle x_req pulse seen in IDLE SHALL yield OWN_x for one cycle followed by a full GUARD.

Reset
REQ-027 While rst is high, the FSM SHALL be IDLE, both grants 0, outputs at idle values, phy_out_addr=0, arb_timeout=0, last-owner=A, and counters 0.
REQ-028 Reset asserted mid-ownership SHALL drop the grant and blank the PHY immediately, without waiting for a clock edge.

Configuration
REQ-029 With macro HUB75_ARB_TIMEOUT_EN defined, a 16-bit counter SHALL count cycles in OWN_x while the other requester's req is high.
REQ-030 When that counter reaches TIMEOUT, the grant SHALL be revoked, the FSM SHALL enter GUARD, and arb_timeout SHALL set and stay set until rst.
REQ-031 Without HUB75_ARB_TIMEOUT_EN, no watchdog logic SHALL exist and arb_timeout SHALL be tied to 0.

Structure
REQ-032 The FSM state encoding and the idle-output constants SHALL live in the shared package hub75_pkg.
REQ-033 The output register plus source mux SHALL be one sub-module, hub75_phy_arb_mux, instantiated once.

Verification
REQ-034 After reset release, b_req=1 for 10 cycles with b_phy_addr=5'h03 -> b_gnt high cycles 2..11, phy_out_addr=3 one cycle after each b input, then 4 blank cycles.
REQ-035 a_req and b_req both rising in the same cycle after reset -> B granted first; after B releases and GUARD ends, A is granted.
REQ-036 a_req held during OWN_B -> a_gnt stays 0 and phy_out_* never reflects a_phy_*; A is granted exactly GUARD_CYCLES+1 cycles after b_req falls.
REQ-037 rst pulsed while in OWN_A -> a_gnt=0 and phy_out_blank=1 within the reset pulse, before any clock edge.
REQ-038 With HUB75_ARB_TIMEOUT_EN and TIMEOUT=16, A holds while b_req=1 -> a_gnt falls after 16 cycles, arb_timeout=1, and B is granted after GUARD.
REQ-039 Without the macro, the same stimulus as REQ-038 -> A keeps ownership indefinitely and arb_timeout stays 0.
